// File: rtl/mbus_timer.sv
// Memory-mapped down-counter timer with prescaler, auto-reload and overflow interrupt.
// Register reads are combinational; all state updates happen on the rising clock edge.
module mbus_timer #(
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] BASE      = ADDR_SIZE'(32'hFFFF_FF00)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] mbus_ain,
  input  logic [WIDTH-1:0]     mbus_din,
  input  logic                 mbus_wen,
  output logic [WIDTH-1:0]     mbus_dout,
  output logic                 mbus_sel,
  output logic                 irq
);

  localparam logic [3:0] OFF_CTRL  = 4'd0;
  localparam logic [3:0] OFF_AR    = 4'd1;
  localparam logic [3:0] OFF_CNT   = 4'd2;
  localparam logic [3:0] OFF_STAT  = 4'd3;
  localparam logic [3:0] OFF_PRESC = 4'd4;

  logic             run, reload, irqen, ov;
  logic [WIDTH-1:0] ar, cnt, presc, psc;

  logic [3:0] off;
  logic       we;
  logic       wr_ctrl, wr_ar, wr_cnt, wr_stat, wr_presc;
  logic       tick, underflow, cnt_upd;

  assign off      = mbus_ain[3:0];
  assign mbus_sel = (mbus_ain[ADDR_SIZE-1:4] == BASE[ADDR_SIZE-1:4]);
  assign we       = mbus_sel & mbus_wen;

  assign wr_ctrl  = we && (off == OFF_CTRL);
  assign wr_ar    = we && (off == OFF_AR);
  assign wr_cnt   = we && (off == OFF_CNT);
  assign wr_stat  = we && (off == OFF_STAT);
  assign wr_presc = we && (off == OFF_PRESC);

  assign tick      = run && (psc == presc);
  assign underflow = tick && (cnt == '0);
  // A CTRL write that stops the timer cancels this tick's counter update, not its OV.
  assign cnt_upd   = tick && !(wr_ctrl && !mbus_din[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run    <= 1'b0;
      reload <= 1'b0;
      irqen  <= 1'b0;
      ov     <= 1'b0;
      ar     <= '0;
      cnt    <= '0;
      presc  <= '0;
      psc    <= '0;
    end else begin
      if (!run || wr_presc || tick) psc <= '0;
      else                          psc <= psc + WIDTH'(1);

      if (wr_ctrl) begin
        run    <= mbus_din[0];
        reload <= mbus_din[1];
        irqen  <= mbus_din[2];
      end else if (underflow && !reload) begin
        run <= 1'b0;
      end

      if (wr_ar)    ar    <= mbus_din;
      if (wr_presc) presc <= mbus_din;

      if (wr_cnt) begin
        cnt <= mbus_din;
      end else if (cnt_upd) begin
        if (cnt != '0)  cnt <= cnt - WIDTH'(1);
        else if (reload) cnt <= ar;
      end

      if (underflow)                     ov <= 1'b1;
      else if (wr_stat && mbus_din[0])   ov <= 1'b0;
    end
  end

  assign irq = ov & irqen;

  always_comb begin
    mbus_dout = '0;
    if (mbus_sel) begin
      case (off)
        OFF_CTRL:  mbus_dout = WIDTH'({irqen, reload, run});
        OFF_AR:    mbus_dout = ar;
        OFF_CNT:   mbus_dout = cnt;
        OFF_STAT:  mbus_dout = WIDTH'(ov);
        OFF_PRESC: mbus_dout = presc;
        default:   mbus_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_timer.sv
// Directed-vector bench for mbus_timer: reads push expected {sel,irq,dout} into a
// scoreboard queue, and a separate monitor pops and compares on each read strobe.
module tb_mbus_timer;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk;
  logic        reset;
  logic [31:0] mbus_ain;
  logic [31:0] mbus_din;
  logic        mbus_wen;
  logic [31:0] mbus_dout;
  logic        mbus_sel;
  logic        irq;
  logic        rd_pulse;

  typedef struct {
    string       name;
    logic        sel;
    logic        irq;
    logic [31:0] dout;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  mbus_timer #(.WIDTH(32), .ADDR_SIZE(32), .BASE(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .mbus_ain (mbus_ain),
    .mbus_din (mbus_din),
    .mbus_wen (mbus_wen),
    .mbus_dout(mbus_dout),
    .mbus_sel (mbus_sel),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ra(input int unsigned o);
    return BASE | 32'(o);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mbus_ain = a;
    mbus_din = d;
    mbus_wen = 1'b1;
    @(posedge clk);
    #1;
    mbus_wen = 1'b0;
    mbus_ain = '0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic es,
                    input logic ei, input logic [31:0] ed);
    exp_t e;
    mbus_ain = a;
    mbus_wen = 1'b0;
    e.name = nm;
    e.sel  = es;
    e.irq  = ei;
    e.dout = ed;
    sb.push_back(e);
    #1 rd_pulse = 1'b1;
    #1 rd_pulse = 1'b0;
  endtask

  always @(posedge rd_pulse) begin
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_read: got sel=%0b irq=%0b dout=%h, required none queued",
               mbus_sel, irq, mbus_dout);
    end else begin
      e = sb.pop_front();
      if ({mbus_sel, irq, mbus_dout} !== {e.sel, e.irq, e.dout}) begin
        n_err++;
        $display("FAIL %s: got sel=%0b irq=%0b dout=%h, required sel=%0b irq=%0b dout=%h",
                 e.name, mbus_sel, irq, mbus_dout, e.sel, e.irq, e.dout);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; mbus_ain = '0; mbus_din = '0; mbus_wen = 1'b0; rd_pulse = 1'b0;
    #2;
    rd("rst_ctrl",  ra(0), 1'b1, 1'b0, 32'd0);
    rd("rst_unsel", 32'h0, 1'b0, 1'b0, 32'd0);
    step(); step();
    reset = 1'b1;

    // Auto-reload countdown with PRESC=0
    wr(ra(1), 32'd3);
    rd("first_wr_ar", ra(1), 1'b1, 1'b0, 32'd3);
    wr(ra(2), 32'd3);
    wr(ra(4), 32'd0);
    wr(ra(0), 32'd3);
    rd("rl_cnt3", ra(2), 1'b1, 1'b0, 32'd3);
    step(); rd("rl_cnt2", ra(2), 1'b1, 1'b0, 32'd2);
    step(); rd("rl_cnt1", ra(2), 1'b1, 1'b0, 32'd1);
    step(); rd("rl_cnt0", ra(2), 1'b1, 1'b0, 32'd0);
    rd("rl_stat0", ra(3), 1'b1, 1'b0, 32'd0);
    step(); rd("rl_reload", ra(2), 1'b1, 1'b0, 32'd3);
    rd("rl_ov", ra(3), 1'b1, 1'b0, 32'd1);
    wr(ra(0), 32'd0);
    rd("stop_suppress", ra(2), 1'b1, 1'b0, 32'd3);
    wr(ra(3), 32'd1);
    rd("rl_ovclr", ra(3), 1'b1, 1'b0, 32'd0);

    // One-shot with PRESC=2
    wr(ra(4), 32'd2);
    wr(ra(2), 32'd1);
    wr(ra(0), 32'd1);
    step(); step();
    rd("os_cnt_pre", ra(2), 1'b1, 1'b0, 32'd1);
    step(); rd("os_cnt0", ra(2), 1'b1, 1'b0, 32'd0);
    rd("os_stat_early", ra(3), 1'b1, 1'b0, 32'd0);
    step(); step();
    rd("os_run_still", ra(0), 1'b1, 1'b0, 32'd1);
    rd("os_stat_still0", ra(3), 1'b1, 1'b0, 32'd0);
    step();
    rd("os_ov", ra(3), 1'b1, 1'b0, 32'd1);
    rd("os_stopped", ra(0), 1'b1, 1'b0, 32'd0);
    step(); step(); step();
    rd("os_hold0", ra(2), 1'b1, 1'b0, 32'd0);
    wr(ra(3), 32'd1);

    // Interrupt enable and W1C vs same-cycle set
    wr(ra(4), 32'd0);
    wr(ra(2), 32'd1);
    wr(ra(0), 32'd5);
    step(); rd("irq_cnt0", ra(2), 1'b1, 1'b0, 32'd0);
    step(); rd("irq_set", ra(3), 1'b1, 1'b1, 32'd1);
    rd("irq_ctrl", ra(0), 1'b1, 1'b1, 32'd4);
    wr(ra(3), 32'd1);
    rd("irq_clr", ra(3), 1'b1, 1'b0, 32'd0);
    wr(ra(2), 32'd1);
    wr(ra(0), 32'd5);
    step();
    wr(ra(3), 32'd1);
    rd("set_wins", ra(3), 1'b1, 1'b1, 32'd1);
    wr(ra(3), 32'd1);
    rd("w1c_after", ra(3), 1'b1, 1'b0, 32'd0);

    // CPU write to CNT beats a tick; CTRL stop suppresses update
    wr(ra(2), 32'd5);
    wr(ra(0), 32'd1);
    wr(ra(2), 32'd7);
    rd("cnt_wr_wins", ra(2), 1'b1, 1'b0, 32'd7);
    step(); rd("cnt_after_wr", ra(2), 1'b1, 1'b0, 32'd6);
    wr(ra(0), 32'd0);
    rd("stop_hold", ra(2), 1'b1, 1'b0, 32'd6);
    wr(ra(1), 32'd9);
    wr(ra(2), 32'd0);
    wr(ra(0), 32'd3);
    wr(ra(0), 32'd0);
    rd("stop_no_reload", ra(2), 1'b1, 1'b0, 32'd0);
    rd("stop_ov_set", ra(3), 1'b1, 1'b0, 32'd1);
    wr(ra(3), 32'd1);

    // Unmapped offsets, out-of-window access, reserved CTRL bits
    for (int unsigned o = 5; o < 16; o++) rd("hole_rd", ra(o), 1'b1, 1'b0, 32'd0);
    rd("win_rd_lo", 32'hFFFF_FE02, 1'b0, 1'b0, 32'd0);
    rd("win_rd_zero", 32'h0000_0001, 1'b0, 1'b0, 32'd0);
    wr(32'hFFFF_FE02, 32'h1234);
    wr(32'h0000_0001, 32'h5678);
    wr(32'h7FFF_FF04, 32'h0F0F);
    for (int unsigned o = 5; o < 16; o++) wr(ra(o), 32'hFFFF_FFFF);
    wr(ra(0), 32'hFFFF_FFF8);
    rd("ctrl_rsv", ra(0), 1'b1, 1'b0, 32'd0);
    rd("keep_ar", ra(1), 1'b1, 1'b0, 32'd9);
    rd("keep_cnt", ra(2), 1'b1, 1'b0, 32'd0);
    rd("keep_presc", ra(4), 1'b1, 1'b0, 32'd0);
    rd("keep_stat", ra(3), 1'b1, 1'b0, 32'd0);

    // Asynchronous reset mid-count with irq active
    wr(ra(1), 32'd5);
    wr(ra(2), 32'd1);
    wr(ra(0), 32'd7);
    step(); step();
    rd("pre_rst_cnt", ra(2), 1'b1, 1'b1, 32'd5);
    step();
    rd("pre_rst_cnt4", ra(2), 1'b1, 1'b1, 32'd4);
    #1 reset = 1'b0;
    rd("async_cnt", ra(2), 1'b1, 1'b0, 32'd0);
    rd("async_ar", ra(1), 1'b1, 1'b0, 32'd0);
    rd("async_ctrl", ra(0), 1'b1, 1'b0, 32'd0);
    step(); step();
    reset = 1'b1;
    step(); step(); step();
    rd("post_rst_cnt", ra(2), 1'b1, 1'b0, 32'd0);
    rd("post_rst_ctrl", ra(0), 1'b1, 1'b0, 32'd0);
    rd("post_rst_stat", ra(3), 1'b1, 1'b0, 32'd0);

    #5;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
